// File: rtl/ysyx_25010008_exu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25010008_exu_pkg
// Shared definitions for the NPC execute stage: control-type, operand-select
// and buffer-state enums, ALU opcode constants, and a helper that maps
// reserved control codes onto CT_ALU.
// ----------------------------------------------------------------------------
package ysyx_25010008_exu_pkg;

    typedef enum logic [2:0] {
        CT_ALU    = 3'd0,
        CT_BRANCH = 3'd1,
        CT_JAL    = 3'd2,
        CT_JALR   = 3'd3,
        CT_LOAD   = 3'd4,
        CT_STORE  = 3'd5
    } ctrl_e;

    typedef enum logic [1:0] {
        S1_RS1  = 2'd0,
        S1_PC   = 2'd1,
        S1_ZERO = 2'd2
    } src1_e;

    typedef enum logic [1:0] {
        S2_RS2  = 2'd0,
        S2_IMM  = 2'd1,
        S2_FOUR = 2'd2
    } src2_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Opcode encoding: 0 = add, bit0 alone = sub, bit0 plus one other bit =
    // compare (result in bit 0), any single bit of [7:1] = logic/shift/copy.
    localparam logic [7:0] ALU_ADD   = 8'h00;
    localparam logic [7:0] ALU_SUB   = 8'h01;
    localparam logic [7:0] ALU_AND   = 8'h02;
    localparam logic [7:0] ALU_OR    = 8'h04;
    localparam logic [7:0] ALU_XOR   = 8'h08;
    localparam logic [7:0] ALU_SLL   = 8'h10;
    localparam logic [7:0] ALU_SRL   = 8'h20;
    localparam logic [7:0] ALU_SRA   = 8'h40;
    localparam logic [7:0] ALU_COPYB = 8'h80;
    localparam logic [7:0] ALU_EQ    = 8'h03;
    localparam logic [7:0] ALU_NE    = 8'h05;
    localparam logic [7:0] ALU_LTU   = 8'h09;
    localparam logic [7:0] ALU_LT    = 8'h11;
    localparam logic [7:0] ALU_GEU   = 8'h21;
    localparam logic [7:0] ALU_GE    = 8'h41;

    // Reserved control codes (6, 7) behave exactly like a plain ALU op.
    function automatic ctrl_e norm_ctrl(input logic [2:0] i_code);
        if (i_code > CT_STORE) begin
            return CT_ALU;
        end
        return ctrl_e'(i_code);
    endfunction

endpackage

// File: rtl/ysyx_25010008_ALU.sv
// ----------------------------------------------------------------------------
// ysyx_25010008_ALU
// Purely combinational integer ALU used by the execute stage.
// Ports:
//   i_op     [7:0]      opcode (ysyx_25010008_exu_pkg::ALU_*)
//   i_a      [XLEN-1:0] operand 1
//   i_b      [XLEN-1:0] operand 2
//   o_result [XLEN-1:0] result; compares return 0/1 in bit 0
// Unrecognised opcodes produce zero.
// ----------------------------------------------------------------------------
module ysyx_25010008_ALU
    import ysyx_25010008_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [7:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held (which would be a latch).
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
            ALU_COPYB: o_result = i_b;
            ALU_EQ:    o_result = {{(XLEN-1){1'b0}}, i_a == i_b};
            ALU_NE:    o_result = {{(XLEN-1){1'b0}}, i_a != i_b};
            ALU_LTU:   o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
            ALU_LT:    o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_GEU:   o_result = {{(XLEN-1){1'b0}}, i_a >= i_b};
            ALU_GE:    o_result = {{(XLEN-1){1'b0}}, $signed(i_a) >= $signed(i_b)};
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25010008_exu.sv
// ----------------------------------------------------------------------------
// ysyx_25010008_exu
// Execute stage between IDU and LSU. Takes one decoded instruction per
// valid/ready handshake, selects ALU operands, resolves branches and jumps,
// and registers the result in a one-entry buffer for the LSU. Taken control
// flow produces a one-cycle redirect pulse; redirect_pc holds the last target.
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   in_valid / in_ready          IDU handshake (in_ready is combinational)
//   in_pc, in_ctrl, in_alu_op    instruction PC, control type, ALU opcode
//   in_src1_sel, in_src2_sel     operand selects
//   in_rs1, in_rs2, in_imm       register data and sign-extended immediate
//   in_rd, in_rd_wen             destination register and write enable
//   out_valid / out_ready        LSU handshake (buffer full / consumed)
//   out_result, out_wdata        ALU result (link/address), store data
//   out_ctrl, out_rd, out_rd_wen registered control, destination, enable
//   redirect_valid, redirect_pc  taken-control-flow pulse and target
// Build option YSYX_25010008_EXU_PERF_EN adds 64-bit counters
//   perf_inst_cnt (accepted instructions) and perf_redirect_cnt (redirects).
// ----------------------------------------------------------------------------
module ysyx_25010008_exu
    import ysyx_25010008_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_ctrl,
    input  logic [7:0]      in_alu_op,
    input  logic [1:0]      in_src1_sel,
    input  logic [1:0]      in_src2_sel,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_wdata,
    output logic [2:0]      out_ctrl,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef YSYX_25010008_EXU_PERF_EN
    ,
    output logic [63:0]     perf_inst_cnt,
    output logic [63:0]     perf_redirect_cnt
`endif
);

    buf_state_e      r_state;
    buf_state_e      w_state_next;
    logic            w_fire;
    ctrl_e           w_ctrl;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_rs1_imm;
    logic [XLEN-1:0] w_target;
    logic            w_taken;

    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_wdata;
    ctrl_e           r_ctrl;
    logic [4:0]      r_rd;
    logic            r_rd_wen;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    assign w_ctrl = norm_ctrl(in_ctrl);

    // ---------------- Operand selection ----------------
    always_comb begin
        w_op1 = '0;
        case (in_src1_sel)
            S1_RS1:  w_op1 = in_rs1;
            S1_PC:   w_op1 = in_pc;
            default: w_op1 = '0;
        endcase
    end

    always_comb begin
        w_op2 = '0;
        case (in_src2_sel)
            S2_RS2:  w_op2 = in_rs2;
            S2_IMM:  w_op2 = in_imm;
            S2_FOUR: w_op2 = XLEN'(4);
            default: w_op2 = '0;
        endcase
    end

    ysyx_25010008_ALU #(.XLEN(XLEN)) u_alu (
        .i_op     (in_alu_op),
        .i_a      (w_op1),
        .i_b      (w_op2),
        .o_result (w_alu_result)
    );

    // ---------------- Control-flow resolution ----------------
    // Dedicated target adders keep the ALU free for the compare / link value.
    assign w_pc_imm  = in_pc + in_imm;
    assign w_rs1_imm = in_rs1 + in_imm;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc_imm;
        case (w_ctrl)
            CT_BRANCH: w_taken = w_alu_result[0];
            CT_JAL:    w_taken = 1'b1;
            CT_JALR: begin
                w_taken  = 1'b1;
                w_target = {w_rs1_imm[XLEN-1:1], 1'b0};
            end
            default:   w_taken = 1'b0;
        endcase
    end

    // ---------------- Output buffer FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = (r_state == BUF_EMPTY) | out_ready;
        out_valid    = (r_state == BUF_FULL);
        w_fire       = in_valid & in_ready;
        case (r_state)
            BUF_EMPTY: if (w_fire) w_state_next = BUF_FULL;
            // A fire while FULL implies out_ready, so the slot is refilled.
            BUF_FULL:  if (out_ready && !w_fire) w_state_next = BUF_EMPTY;
            default:   w_state_next = BUF_EMPTY;
        endcase
    end

    // ---------------- Result buffer and redirect ----------------
    // NOTE: this is a handful of flops rather than a memory, so every data
    // register is reset to give the LSU a defined value out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_result         <= '0;
            r_wdata          <= '0;
            r_ctrl           <= CT_ALU;
            r_rd             <= '0;
            r_rd_wen         <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            if (w_fire) begin
                r_result <= w_alu_result;
                r_wdata  <= in_rs2;
                r_ctrl   <= w_ctrl;
                r_rd     <= in_rd;
                r_rd_wen <= in_rd_wen & (w_ctrl != CT_BRANCH);
            end
            // Pulse regardless of out_ready: the front end must see it now.
            r_redirect_valid <= w_fire & w_taken;
            if (w_fire && w_taken) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    assign out_result     = r_result;
    assign out_wdata      = r_wdata;
    assign out_ctrl       = r_ctrl;
    assign out_rd         = r_rd;
    assign out_rd_wen     = r_rd_wen;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

`ifdef YSYX_25010008_EXU_PERF_EN
    logic [63:0] r_perf_inst_cnt;
    logic [63:0] r_perf_redirect_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_inst_cnt     <= '0;
            r_perf_redirect_cnt <= '0;
        end else begin
            if (w_fire) begin
                r_perf_inst_cnt <= r_perf_inst_cnt + 64'd1;
            end
            if (w_fire && w_taken) begin
                r_perf_redirect_cnt <= r_perf_redirect_cnt + 64'd1;
            end
        end
    end

    assign perf_inst_cnt     = r_perf_inst_cnt;
    assign perf_redirect_cnt = r_perf_redirect_cnt;
`endif

endmodule
